// File: rtl/keypad_defs.sv
// Shared definitions for the keypad scanner: FSM state encoding, the no-key code
// and the helper that turns a latched row pattern plus column into a key index.
// Latency: n/a (types and a combinational function only).
// Backpressure: n/a.
package keypad_defs;

  typedef enum logic [2:0] {
    SCAN      = 3'd0,
    DEB_PRESS = 3'd1,
    PRESSED   = 3'd2,
    WAIT_REL  = 3'd3,
    DEB_REL   = 3'd4
  } state_e;

  localparam logic [4:0] KEY_NONE = 5'd31;

  // Lowest-index low row wins when several rows in one column are pressed.
  function automatic logic [4:0] key_index(input logic [3:0] pat, input logic [1:0] col);
    logic [1:0] row;
    row = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (!pat[i]) row = i[1:0];
    end
    return {1'b0, row, col};
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
// Latency: first tick DIV clocks after reset release, then every DIV clocks.
// Backpressure: none; the tick cannot be stalled.
module ms_tick_gen #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int             W    = $clog2(DIV);
  localparam logic [W-1:0]   LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Count 0..DIV-1 and wrap.
  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
  end

  // Divider register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: walks one low column, debounces press/release, reports key index.
// Latency: key accepted after DEBOUNCE_TICKS identical tick samples; key_ready rises one clock later.
// Backpressure: none; key_ready is a fixed-length strobe, key_held a level.
module keypad_scan
  import keypad_defs::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int READY_CYCLES   = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [4:0] keycode,
  output logic       key_ready,
  output logic       key_held
);

  localparam int              DB_W    = $clog2(DEBOUNCE_TICKS + 1);
  localparam int              RC_W    = (READY_CYCLES > 1) ? $clog2(READY_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_TICKS - 1);
  localparam logic [RC_W-1:0] RC_LOAD = RC_W'(READY_CYCLES - 1);

  logic            tick;
  logic [3:0]      sync_q, rs_q;
  state_e          state_q, state_d;
  logic [1:0]      col_q, col_d;
  logic [3:0]      p_q, p_d;
  logic [DB_W-1:0] db_q, db_d;
  logic [4:0]      keycode_q, keycode_d;
  logic            held_q, held_d;
  logic            ready_q, ready_d;
  logic [RC_W-1:0] rcnt_q, rcnt_d;

  ms_tick_gen #(.DIV(SCAN_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Two-flop synchroniser for the asynchronous row lines; idle rows read high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 4'hF;
      rs_q   <= 4'hF;
    end else begin
      sync_q <= row_in;
      rs_q   <= sync_q;
    end
  end

  // Next-state logic: scan/debounce FSM on ticks, ready counter every clock.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    p_d       = p_q;
    db_d      = db_q;
    keycode_d = keycode_q;
    held_d    = held_q;
    ready_d   = ready_q;
    rcnt_d    = rcnt_q;

    if (ready_q) begin
      if (rcnt_q == '0) ready_d = 1'b0;
      else              rcnt_d  = rcnt_q - RC_W'(1);
    end

    case (state_q)
      SCAN: begin
        if (tick) begin
          if (rs_q == 4'hF) begin
            col_d = col_q + 2'd1;
          end else begin
            p_d     = rs_q;
            db_d    = DB_W'(1);
            state_d = DEB_PRESS;
          end
        end
      end
      DEB_PRESS: begin
        if (tick) begin
          if (rs_q == p_q) begin
            if (db_q >= DB_LAST) state_d = PRESSED;
            else                 db_d    = db_q + DB_W'(1);
          end else begin
            db_d    = '0;
            state_d = SCAN;
          end
        end
      end
      PRESSED: begin
        // A reload here covers a press accepted while the previous strobe is still high.
        keycode_d = key_index(p_q, col_q);
        held_d    = 1'b1;
        ready_d   = 1'b1;
        rcnt_d    = RC_LOAD;
        db_d      = '0;
        state_d   = WAIT_REL;
      end
      WAIT_REL: begin
        if (tick && rs_q == 4'hF) begin
          db_d    = DB_W'(1);
          state_d = DEB_REL;
        end
      end
      DEB_REL: begin
        if (tick) begin
          if (rs_q == 4'hF) begin
            if (db_q >= DB_LAST) begin
              held_d  = 1'b0;
              col_d   = col_q + 2'd1;
              db_d    = '0;
              state_d = SCAN;
            end else begin
              db_d = db_q + DB_W'(1);
            end
          end else begin
            db_d    = '0;
            state_d = WAIT_REL;
          end
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SCAN;
      col_q     <= 2'd0;
      p_q       <= 4'hF;
      db_q      <= '0;
      keycode_q <= KEY_NONE;
      held_q    <= 1'b0;
      ready_q   <= 1'b0;
      rcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      p_q       <= p_d;
      db_q      <= db_d;
      keycode_q <= keycode_d;
      held_q    <= held_d;
      ready_q   <= ready_d;
      rcnt_q    <= rcnt_d;
    end
  end

  assign col_out   = ~(4'b0001 << col_q);
  assign keycode   = keycode_q;
  assign key_ready = ready_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan with a matrix keypad model and an expected-keycode scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_keypad_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [4:0] keycode;
  logic       key_ready;
  logic       key_held;

  logic [15:0] key_dn = '0;   // bit r*4+c = key at row r, column c is pressed
  int          total = 0;
  int          bad   = 0;
  int          exp_q[$];
  int          rises = 0;
  int          len = 0;
  int          last_len = 0;
  logic        prev_rdy = 1'b0;

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_TICKS(3), .READY_CYCLES(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .row_in    (row_in),
    .col_out   (col_out),
    .keycode   (keycode),
    .key_ready (key_ready),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Keypad: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) row_in[r] = ~|(key_dn[r*4 +: 4] & ~col_out);
  end

  // Count key_ready rising edges and measure each pulse in clocks.
  always @(posedge clk) begin
    #1;
    if (key_ready && !prev_rdy) rises = rises + 1;
    if (key_ready) len = len + 1;
    else if (prev_rdy) begin
      last_len = len;
      len = 0;
    end
    prev_rdy = key_ready;
  end

  task automatic wait_level(input int sel, input logic lvl, input int budget, output bit ok);
    logic v;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      v = (sel == 0) ? key_ready : key_held;
      if (v === lvl) ok = 1'b1;
    end
  endtask

  task automatic wait_col(input logic [3:0] v, input bit eq, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if ((col_out === v) == eq) ok = 1'b1;
    end
  endtask

  // Press key(s) already set in key_dn, expect one strobe carrying the queued code.
  task automatic expect_press(input string nm);
    bit ok;
    int e;
    wait_level(0, 1'b1, 120, ok);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    total++;
    if (!ok) begin bad++; $display("FAIL %s_ready_timeout got=none want=key_ready", nm); end
    total++;
    if (int'(keycode) !== e) begin bad++; $display("FAIL %s_keycode got=%0d want=%0d", nm, keycode, e); end
    total++;
    if (key_held !== 1'b1) begin bad++; $display("FAIL %s_held got=%b want=1", nm, key_held); end
    wait_level(0, 1'b0, 40, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL %s_ready_stuck got=1 want=0", nm); end
  endtask

  task automatic test_reset();
    logic [3:0] seq [4];
    logic [3:0] last;
    int gap;
    seq[0] = 4'b1101; seq[1] = 4'b1011; seq[2] = 4'b0111; seq[3] = 4'b1110;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    total++;
    if (col_out !== 4'b1110) begin bad++; $display("FAIL reset_col got=%b want=1110", col_out); end
    total++;
    if (keycode !== 5'd31) begin bad++; $display("FAIL reset_keycode got=%0d want=31", keycode); end
    total++;
    if (key_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", key_ready); end
    total++;
    if (key_held !== 1'b0) begin bad++; $display("FAIL reset_held got=%b want=0", key_held); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last = col_out;
    for (int k = 0; k < 4; k++) begin
      gap = 0;
      do begin @(negedge clk); gap++; end while (col_out === last && gap < 12);
      total++;
      if (col_out !== seq[k]) begin bad++; $display("FAIL scan_col%0d got=%b want=%b", k, col_out, seq[k]); end
      if (k > 0) begin
        total++;
        if (gap != 4) begin bad++; $display("FAIL scan_gap%0d got=%0d want=4", k, gap); end
      end
      last = col_out;
    end
  endtask

  task automatic test_clean_press();
    bit ok;
    int r0;
    r0 = rises;
    exp_q.push_back(9);
    key_dn[2*4+1] = 1'b1;
    expect_press("clean");
    total++;
    if (last_len != 8) begin bad++; $display("FAIL clean_ready_len got=%0d want=8", last_len); end
    total++;
    if (key_held !== 1'b1) begin bad++; $display("FAIL clean_held_after_ready got=%b want=1", key_held); end
    key_dn = '0;
    wait_level(1, 1'b0, 120, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL clean_release_timeout got=held want=released"); end
    total++;
    if (keycode !== 5'd9) begin bad++; $display("FAIL clean_keycode_kept got=%0d want=9", keycode); end
    total++;
    if (rises != r0 + 1) begin bad++; $display("FAIL clean_ready_count got=%0d want=%0d", rises - r0, 1); end
  endtask

  task automatic test_bounce();
    bit ok;
    int r0;
    r0 = rises;
    wait_col(4'b0111, 1'b0, 40, ok);
    wait_col(4'b0111, 1'b1, 40, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL bounce_col3_timeout got=%b want=0111", col_out); end
    key_dn[0*4+3] = 1'b1;
    repeat (4) @(negedge clk);
    key_dn = '0;
    repeat (4) @(negedge clk);
    total++;
    if (col_out !== 4'b0111) begin bad++; $display("FAIL bounce_col_hold got=%b want=0111", col_out); end
    repeat (4) @(negedge clk);
    total++;
    if (col_out !== 4'b1110) begin bad++; $display("FAIL bounce_col_next got=%b want=1110", col_out); end
    repeat (20) @(negedge clk);
    total++;
    if (rises != r0) begin bad++; $display("FAIL bounce_no_ready got=%0d want=0", rises - r0); end
  endtask

  task automatic test_two_keys();
    bit ok;
    int r0;
    r0 = rises;
    exp_q.push_back(4);
    key_dn[1*4+0] = 1'b1;
    key_dn[3*4+0] = 1'b1;
    expect_press("two");
    key_dn[3*4+0] = 1'b0;
    repeat (40) @(negedge clk);
    total++;
    if (key_held !== 1'b1) begin bad++; $display("FAIL two_partial_held got=%b want=1", key_held); end
    total++;
    if (rises != r0 + 1) begin bad++; $display("FAIL two_partial_ready got=%0d want=1", rises - r0); end
    key_dn = '0;
    wait_level(1, 1'b0, 120, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL two_release_timeout got=held want=released"); end
  endtask

  task automatic test_release_bounce();
    bit ok;
    int r0;
    r0 = rises;
    exp_q.push_back(2);
    key_dn[0*4+2] = 1'b1;
    expect_press("relb");
    key_dn = '0;
    repeat (8) @(negedge clk);
    key_dn[0*4+2] = 1'b1;
    repeat (24) @(negedge clk);
    total++;
    if (key_held !== 1'b1) begin bad++; $display("FAIL relb_held got=%b want=1", key_held); end
    total++;
    if (rises != r0 + 1) begin bad++; $display("FAIL relb_ready_count got=%0d want=1", rises - r0); end
    key_dn = '0;
    wait_level(1, 1'b0, 120, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL relb_release_timeout got=held want=released"); end
    total++;
    if (keycode !== 5'd2) begin bad++; $display("FAIL relb_keycode_kept got=%0d want=2", keycode); end
  endtask

  task automatic test_reset_mid_press();
    bit ok;
    int r0;
    wait_col(4'b1011, 1'b0, 40, ok);
    key_dn[1*4+2] = 1'b1;
    wait_col(4'b1011, 1'b1, 40, ok);
    repeat (6) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    total++;
    if ({col_out, keycode, key_ready, key_held} !== {4'b1110, 5'd31, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL rst_deb col=%b key=%0d rdy=%b held=%b want=1110/31/0/0", col_out, keycode, key_ready, key_held);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    r0 = rises;
    repeat (8) @(negedge clk);
    total++;
    if (rises != r0 || key_ready !== 1'b0) begin bad++; $display("FAIL rst_deb_no_ready got=%0d want=0", rises - r0); end
    exp_q.push_back(6);
    expect_press("rst_new");
    wait_level(0, 1'b1, 1, ok);
    key_dn = '0;
    exp_q.push_back(7);
    key_dn[1*4+3] = 1'b1;
    wait_level(1, 1'b0, 120, ok);
    wait_level(0, 1'b1, 120, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rst_rdy_timeout got=none want=key_ready"); end
    void'(exp_q.pop_front());
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    total++;
    if ({col_out, keycode, key_ready, key_held} !== {4'b1110, 5'd31, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL rst_rdy col=%b key=%0d rdy=%b held=%b want=1110/31/0/0", col_out, keycode, key_ready, key_held);
    end
    key_dn = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    r0 = rises;
    repeat (60) @(negedge clk);
    total++;
    if (rises != r0 || key_held !== 1'b0 || keycode !== 5'd31) begin
      bad++;
      $display("FAIL rst_rdy_quiet got=rises%0d/held%b/key%0d want=0/0/31", rises - r0, key_held, keycode);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_two_keys();
    test_release_bounce();
    test_reset_mid_press();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
